// File: rtl/ysyx_22050078_div_unit_pkg.sv
// ysyx_22050078_div_unit_pkg: shared widths, iteration counts and FSM states for the divider
package ysyx_22050078_div_unit_pkg;
  localparam int XLEN = 64;
  localparam int CNT_W = 7;
  localparam int WORD_ITER = 32;
  localparam int DWORD_ITER = 64;
  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_BUSY = 2'd1,
    DIV_ST_DONE = 2'd2
  } div_state_e;
  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] x);
    return {{(XLEN-32){x[31]}}, x[31:0]};
  endfunction
endpackage

// File: rtl/ysyx_22050078_div_unit.sv
// ysyx_22050078_div_unit: multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms
module ysyx_22050078_div_unit
  import ysyx_22050078_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_signed,
  input  logic            i_word,
  input  logic            i_rem,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);
  div_state_e state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] q, r, d;
  logic word_q, rem_q, neg_q, neg_r;
  logic [XLEN-1:0] a_x, b_x, a_abs, b_abs, sp_res, q_nx, r_nx, quo, rmd, res;
  logic [XLEN:0] r_sh, diff;
  logic s1, s2, div0, ovf, special, accept, last;
  assign o_ready = state == DIV_ST_IDLE;
  assign o_valid = state == DIV_ST_DONE;
  assign accept = i_valid && o_ready && !i_flush;
  assign a_x = i_word ? (i_signed ? sext_word(i_dividend) : {32'b0, i_dividend[31:0]}) : i_dividend;
  assign b_x = i_word ? (i_signed ? sext_word(i_divisor) : {32'b0, i_divisor[31:0]}) : i_divisor;
  assign s1 = i_signed && a_x[XLEN-1];
  assign s2 = i_signed && b_x[XLEN-1];
  assign a_abs = s1 ? -a_x : a_x;
  assign b_abs = s2 ? -b_x : b_x;
  assign div0 = b_x == '0;
  // W operands are already sign-extended, so the most-negative test is per width on a_x
  assign ovf = i_signed && &b_x &&
               (a_x == (i_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  assign special = div0 || ovf;
  assign sp_res = i_rem ? (div0 ? a_x : '0) : (div0 ? '1 : a_x);
  // W dividends are pre-shifted to the top so both widths iterate MSB-first from bit XLEN-1
  assign r_sh = {r, q[XLEN-1]};
  assign diff = r_sh - {1'b0, d};
  assign q_nx = {q[XLEN-2:0], ~diff[XLEN]};
  assign r_nx = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
  assign last = cnt == (word_q ? CNT_W'(WORD_ITER - 1) : CNT_W'(DWORD_ITER - 1));
  assign quo = neg_q ? -q_nx : q_nx;
  assign rmd = neg_r ? -r_nx : r_nx;
  assign res = rem_q ? rmd : quo;
  always_comb begin
    state_nx = state;
    if (i_flush) state_nx = DIV_ST_IDLE;
    else if (state == DIV_ST_IDLE && i_valid) state_nx = special ? DIV_ST_DONE : DIV_ST_BUSY;
    else if (state == DIV_ST_BUSY && last) state_nx = DIV_ST_DONE;
    else if (state == DIV_ST_DONE && i_ready) state_nx = DIV_ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_ST_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      q <= '0;
      r <= '0;
      d <= '0;
      word_q <= 1'b0;
      rem_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      o_result <= '0;
    end else if (accept) begin
      cnt <= '0;
      q <= i_word ? {a_abs[31:0], 32'b0} : a_abs;
      r <= '0;
      d <= b_abs;
      word_q <= i_word;
      rem_q <= i_rem;
      neg_q <= s1 ^ s2;
      neg_r <= s1;
      if (special) o_result <= i_word ? sext_word(sp_res) : sp_res;
    end else if (state == DIV_ST_BUSY && !i_flush) begin
      cnt <= cnt + 1'b1;
      q <= q_nx;
      r <= r_nx;
      if (last) o_result <= word_q ? sext_word(res) : res;
    end
  end
endmodule

// File: tb/tb_ysyx_22050078_div_unit.sv
// tb_ysyx_22050078_div_unit: randomized and directed checks of the divider against an arithmetic model
module tb_ysyx_22050078_div_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_valid = 1'b0, i_signed = 1'b0, i_word = 1'b0, i_rem = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
  logic [63:0] i_dividend = '0, i_divisor = '0;
  logic o_ready, o_valid;
  logic [63:0] o_result;
  int checks = 0, failures = 0;
  logic pending = 1'b0;
  logic [63:0] exp_res = '0;

  ysyx_22050078_div_unit dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_dividend(i_dividend), .i_divisor(i_divisor), .i_signed(i_signed),
    .i_word(i_word), .i_rem(i_rem), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic sg, input logic wd, input logic rm);
    logic [31:0] a32, b32, r32;
    int sa, sb;
    longint la, lb;
    logic [63:0] r64;
    if (wd) begin
      a32 = a[31:0]; b32 = b[31:0]; sa = a32; sb = b32;
      if (b32 == 0) r32 = rm ? a32 : 32'hFFFF_FFFF;
      else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rm ? 32'h0 : a32;
      else if (sg) r32 = rm ? sa % sb : sa / sb;
      else r32 = rm ? a32 % b32 : a32 / b32;
      return {{32{r32[31]}}, r32};
    end
    la = a; lb = b;
    if (b == 0) r64 = rm ? a : '1;
    else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) r64 = rm ? 64'h0 : a;
    else if (sg) r64 = rm ? la % lb : la / lb;
    else r64 = rm ? a % b : a / b;
    return r64;
  endfunction

  function automatic int edges_to_valid(input logic [63:0] a, input logic [63:0] b,
                                        input logic sg, input logic wd);
    logic zero, ovf;
    zero = wd ? b[31:0] == 0 : b == 0;
    ovf = sg && (wd ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                    : (a == 64'h8000_0000_0000_0000 && b == '1));
    return (zero || ovf) ? 0 : (wd ? 32 : 64);
  endfunction

  // Continuous protocol/result checker, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      chk("o_ready_idle", o_ready, !pending);
      if (o_valid) begin
        chk("valid_only_pending", pending, 1'b1);
        chk("result", o_result, exp_res);
      end
    end
  end

  task automatic start(input logic [63:0] a, input logic [63:0] b,
                       input logic sg, input logic wd, input logic rm);
    @(negedge clk);
    i_dividend = a; i_divisor = b; i_signed = sg; i_word = wd; i_rem = rm; i_valid = 1'b1;
    exp_res = model(a, b, sg, wd, rm);
    @(posedge clk);
    pending = 1'b1;
    #1 i_valid = 1'b0;
  endtask

  task automatic finish(input int lat_exp, input int hold);
    int lat = 0;
    logic [63:0] first;
    @(negedge clk);
    while (!o_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", 64'(lat), 64'(lat_exp));
    first = o_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", o_valid, 1'b1);
      chk("hold_stable", o_result, first);
    end
    i_ready = 1'b1;
    @(posedge clk);
    #1 pending = 1'b0;
    i_ready = 1'b0;
  endtask

  task automatic run(input logic [63:0] a, input logic [63:0] b,
                     input logic sg, input logic wd, input logic rm, input int hold);
    start(a, b, sg, wd, rm);
    finish(edges_to_valid(a, b, sg, wd), hold);
  endtask

  task automatic run_lit(input logic [63:0] a, input logic [63:0] b, input logic sg,
                         input logic wd, input logic rm, input int lat, input logic [63:0] lit);
    chk("model_pin", model(a, b, sg, wd, rm), lit);
    chk("latency_pin", 64'(edges_to_valid(a, b, sg, wd)), 64'(lat));
    run(a, b, sg, wd, rm, 0);
  endtask

  initial begin
    logic [63:0] a, b;
    logic sg, wd, rm;
    #1;
    chk("reset_ready", o_ready, 1'b1);
    chk("reset_valid", o_valid, 1'b0);
    chk("reset_result", o_result, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_lit(64'd100, 64'd7, 0, 0, 0, 64, 64'd14);
    run_lit(64'd100, 64'd7, 0, 0, 1, 64, 64'd2);
    run_lit(-64'sd7, 64'd2, 1, 0, 0, 64, 64'hFFFF_FFFF_FFFF_FFFD);
    run_lit(-64'sd7, 64'd2, 1, 0, 1, 64, 64'hFFFF_FFFF_FFFF_FFFF);
    run_lit(64'd5, 64'd0, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_lit(64'd5, 64'd0, 0, 0, 1, 0, 64'd5);
    run_lit(64'h8000_0000, 64'hFFFF_FFFF, 1, 1, 0, 0, 64'hFFFF_FFFF_8000_0000);
    run_lit(64'h8000_0000_0000_0000, '1, 1, 0, 0, 0, 64'h8000_0000_0000_0000);
    run_lit(64'h8000_0000_0000_0000, '1, 1, 0, 1, 0, 64'h0);
    run_lit(64'h1_FFFF_FFFF, 64'd1, 0, 1, 0, 32, 64'hFFFF_FFFF_FFFF_FFFF);
    run_lit(-64'sd7, 64'd3, 1, 1, 1, 32, 64'hFFFF_FFFF_FFFF_FFFF);
    start(64'd1000, 64'd9, 0, 0, 0);
    finish(64, 5);
    // Flush mid-iteration with a competing request that must be dropped
    start(64'd12345, 64'd17, 0, 0, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    i_flush = 1'b1; i_valid = 1'b1;
    @(posedge clk);
    #1 pending = 1'b0;
    i_flush = 1'b0; i_valid = 1'b0;
    repeat (80) @(negedge clk);
    chk("flush_idle", o_ready, 1'b1);
    // Asynchronous reset in the middle of an operation
    start(64'd999, 64'd3, 0, 0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    pending = 1'b0;
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_result", o_result, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    chk("rst_no_valid", o_valid, 1'b0);
    for (int n = 0; n < 60; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      sg = 1'($urandom); wd = 1'($urandom); rm = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = 64'h0;
        1: b = 64'($urandom_range(1, 20)) * (sg ? -64'sd1 : 64'sd1);
        2: begin a = wd ? 64'h8000_0000 : 64'h8000_0000_0000_0000; b = '1; sg = 1'b1; end
        3: a = 64'($urandom_range(0, 1000));
        4: b = b >> $urandom_range(1, 63);
        default: ;
      endcase
      run(a, b, sg, wd, rm, $urandom_range(0, 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
